bsram_shared_port_ctrl: RTL and testbench

Controller that shares one BSRAM_byte_en instance between two requesters, for example instruction fetch and data access in a small core. Each requester has its own valid/ready request port and response port. A round-robin arbiter grants at most one access per cycle. After reset the block can optionally zero-fill the whole memory before it accepts any traffic.

---
 rtl/bsram_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/bsram_shared_port_ctrl.sv | 126 ++++++++++++
 tb/tb_bsram_shared_port_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsram_ctrl_pkg.sv
// Shared definitions for the shared-port BSRAM controller.
//   ctrl_state_t   : controller state (zero-fill or normal arbitration)
//   PORT_0/PORT_1  : requester port identifiers used for response routing
package bsram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clock, reset : clock and asynchronous active-high reset
//   i_enable     : when low no grant is issued
//   i_valid[1:0] : request vector, bit k = requester k
//   o_grant[1:0] : one-hot grant (all zero when nothing is granted)
// The pointer names the port that wins a tie; after every grant it moves
// to the port that was not granted.
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_enable,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);
    logic       r_ptr;
    logic [1:0] w_req;

    assign w_req = i_valid & {2{i_enable}};

    always_comb begin
        o_grant = w_req;
        if (w_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (o_grant[0]) begin
            r_ptr <= 1'b1;
        end else if (o_grant[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/bsram_shared_port_ctrl.sv
// Shares one byte-enabled BSRAM between two valid/ready requesters.
//   clock, reset                 : clock and asynchronous active-high reset
//   reqk*                        : request port k (valid/ready, write, address, data, byte enable)
//   respkValid, respkData        : read response for port k, one cycle after the grant
//   mem*                         : drive the BSRAM; memReadData arrives one cycle after memReadEnable
//   initDone                     : zero-fill finished, normal arbitration running
// After reset the memory is optionally zero-filled (one word per cycle)
// before any request is accepted.
module bsram_shared_port_ctrl
    import bsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0Valid,
    output logic                    req0Ready,
    input  logic                    req0Write,
    input  logic [ADDR_WIDTH-1:0]   req0Address,
    input  logic [DATA_WIDTH-1:0]   req0Data,
    input  logic [DATA_WIDTH/8-1:0] req0ByteEnable,
    output logic                    resp0Valid,
    output logic [DATA_WIDTH-1:0]   resp0Data,
    input  logic                    req1Valid,
    output logic                    req1Ready,
    input  logic                    req1Write,
    input  logic [ADDR_WIDTH-1:0]   req1Address,
    input  logic [DATA_WIDTH-1:0]   req1Data,
    input  logic [DATA_WIDTH/8-1:0] req1ByteEnable,
    output logic                    resp1Valid,
    output logic [DATA_WIDTH-1:0]   resp1Data,
    output logic                    memReadEnable,
    output logic [ADDR_WIDTH-1:0]   memReadAddress,
    output logic                    memWriteEnable,
    output logic [DATA_WIDTH/8-1:0] memWriteByteEnable,
    output logic [ADDR_WIDTH-1:0]   memWriteAddress,
    output logic [DATA_WIDTH-1:0]   memWriteData,
    input  logic [DATA_WIDTH-1:0]   memReadData,
    output logic                    initDone
);
    localparam int BE_W = DATA_WIDTH / 8;

    ctrl_state_t             r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_pending;
    logic                    r_pend_port;

    logic                    w_run;
    logic                    w_init;
    logic [1:0]              w_grant;
    logic                    w_any;
    logic                    w_gport;
    logic                    w_wr;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [BE_W-1:0]         w_be;

    // Qualifying with reset keeps every output quiet while reset is held,
    // including the INIT_ON_RESET=0 case where the state register sits in RUN.
    assign w_run  = (r_state == ST_RUN)  && !reset;
    assign w_init = (r_state == ST_INIT) && !reset;

    rr_arbiter_2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .i_enable (w_run),
        .i_valid  ({req1Valid, req0Valid}),
        .o_grant  (w_grant)
    );

    assign req0Ready = w_grant[0];
    assign req1Ready = w_grant[1];

    // Grant is one-hot, so bit 1 alone identifies the winning port.
    assign w_any   = |w_grant;
    assign w_gport = w_grant[1];
    assign w_wr    = w_gport ? req1Write      : req0Write;
    assign w_addr  = w_gport ? req1Address    : req0Address;
    assign w_data  = w_gport ? req1Data       : req0Data;
    assign w_be    = w_gport ? req1ByteEnable : req0ByteEnable;

    assign memReadEnable      = w_any && !w_wr;
    assign memReadAddress     = w_addr;
    assign memWriteEnable     = w_init || (w_any && w_wr);
    assign memWriteAddress    = w_init ? r_cnt : w_addr;
    assign memWriteData       = w_init ? '0 : w_data;
    assign memWriteByteEnable = w_init ? {BE_W{1'b1}} : w_be;

    assign initDone = w_run;

    // Read data is not buffered: the BSRAM output is valid exactly in the
    // cycle after the grant, which is when the pending bit is set.
    assign resp0Valid = r_pending && (r_pend_port == PORT_0);
    assign resp1Valid = r_pending && (r_pend_port == PORT_1);
    assign resp0Data  = memReadData;
    assign resp1Data  = memReadData;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_pend_port <= PORT_0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // All-ones means this cycle writes the last word.
                    if (&r_cnt) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
            r_pending <= memReadEnable;
            if (memReadEnable) begin
                r_pend_port <= w_gport;
            end
        end
    end

endmodule

// File: tb/tb_bsram_shared_port_ctrl.sv
module tb_bsram_shared_port_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0Valid = 0, req0Write = 0, req1Valid = 0, req1Write = 0;
    logic [AW-1:0] req0Address = 0, req1Address = 0;
    logic [DW-1:0] req0Data = 0, req1Data = 0;
    logic [3:0]    req0ByteEnable = 0, req1ByteEnable = 0;
    logic          req0Ready, req1Ready, resp0Valid, resp1Valid;
    logic [DW-1:0] resp0Data, resp1Data;
    logic          memReadEnable, memWriteEnable, initDone;
    logic [AW-1:0] memReadAddress, memWriteAddress;
    logic [3:0]    memWriteByteEnable;
    logic [DW-1:0] memWriteData;
    logic [DW-1:0] bram_rd;
    logic [DW-1:0] bram [DEPTH];
    logic          preload_req = 1'b0;

    always #5 clock = ~clock;

    bsram_shared_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ON_RESET(1)) dut (
        .clock(clock), .reset(reset),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Write(req0Write),
        .req0Address(req0Address), .req0Data(req0Data), .req0ByteEnable(req0ByteEnable),
        .resp0Valid(resp0Valid), .resp0Data(resp0Data),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Write(req1Write),
        .req1Address(req1Address), .req1Data(req1Data), .req1ByteEnable(req1ByteEnable),
        .resp1Valid(resp1Valid), .resp1Data(resp1Data),
        .memReadEnable(memReadEnable), .memReadAddress(memReadAddress),
        .memWriteEnable(memWriteEnable), .memWriteByteEnable(memWriteByteEnable),
        .memWriteAddress(memWriteAddress), .memWriteData(memWriteData),
        .memReadData(bram_rd), .initDone(initDone)
    );

    // Behavioural BSRAM_byte_en: registered read, byte-masked write.
    always @(posedge clock) begin
        if (preload_req) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= 32'hFFFF_FFFF;
        end else begin
            if (memReadEnable) bram_rd <= bram[memReadAddress];
            if (memWriteEnable) begin
                for (int b = 0; b < 4; b++)
                    if (memWriteByteEnable[b])
                        bram[memWriteAddress][8*b +: 8] <= memWriteData[8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    // Observations taken at the falling edge of the current cycle.
    logic          s_r0, s_r1, s_rv0, s_rv1, s_done, s_we, s_re;
    logic [DW-1:0] s_rd0, s_rd1, s_wd;
    logic [AW-1:0] s_wa;
    logic [3:0]    s_wbe;

    // Reference model: memory contents, tie-break port, outstanding read.
    logic [DW-1:0] exp_mem [DEPTH];
    int            m_prio = 0;
    logic          m_pv = 0;
    int            m_pport = 0;
    logic [DW-1:0] m_pdata = 0;
    logic          e_g0, e_g1, e_rv0, e_rv1;
    logic [DW-1:0] e_rdata;

    task automatic tick;
        @(negedge clock);
        s_r0 = req0Ready; s_r1 = req1Ready; s_rv0 = resp0Valid; s_rv1 = resp1Valid;
        s_rd0 = resp0Data; s_rd1 = resp1Data; s_done = initDone;
        s_we = memWriteEnable; s_re = memReadEnable; s_wa = memWriteAddress;
        s_wd = memWriteData; s_wbe = memWriteByteEnable;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        req0Valid = 0; req1Valid = 0; req0Write = 0; req1Write = 0;
    endtask

    // Predicts this cycle's grant and the response of the previous grant,
    // then applies the accepted access to the model.
    task automatic model_cycle;
        int g;
        logic wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0] be;
        e_rv0 = m_pv && (m_pport == 0);
        e_rv1 = m_pv && (m_pport == 1);
        e_rdata = m_pdata;
        if (req0Valid && req1Valid) g = m_prio;
        else if (req0Valid) g = 0;
        else if (req1Valid) g = 1;
        else g = -1;
        e_g0 = (g == 0);
        e_g1 = (g == 1);
        m_pv = 0;
        if (g >= 0) begin
            if (g == 0) begin wr = req0Write; a = req0Address; d = req0Data; be = req0ByteEnable; end
            else        begin wr = req1Write; a = req1Address; d = req1Data; be = req1ByteEnable; end
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                m_pv = 1; m_pport = g; m_pdata = exp_mem[a];
            end
            m_prio = (g == 0) ? 1 : 0;
            $display("txn: port %0d %s addr %0d data %h be %b", g, wr ? "write" : "read", a, d, be);
        end
    endtask

    task automatic model_reset;
        m_prio = 0; m_pv = 0; m_pport = 0; m_pdata = 0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 0;
    endtask

    task automatic test_reset;
        reset = 1; preload_req = 1;
        req0Valid = 1; req1Valid = 1; req0Write = 0; req1Write = 1;
        repeat (2) @(posedge clock);
        preload_req = 0;
        @(posedge clock);
        @(negedge clock);
        n_checks++; if (req0Ready !== 0 || req1Ready !== 0) $display("FAIL reset_ready got %b%b want 00", req1Ready, req0Ready); else n_pass++;
        n_checks++; if (resp0Valid !== 0 || resp1Valid !== 0) $display("FAIL reset_resp got %b%b want 00", resp1Valid, resp0Valid); else n_pass++;
        n_checks++; if (memReadEnable !== 0 || memWriteEnable !== 0) $display("FAIL reset_mem_en got re=%b we=%b want 0 0", memReadEnable, memWriteEnable); else n_pass++;
        n_checks++; if (initDone !== 0) $display("FAIL reset_initdone got %b want 0", initDone); else n_pass++;
    endtask

    task automatic test_init;
        @(posedge clock); #1;
        reset = 0;
        req0Valid = 1; req0Write = 0; req0Address = 0;
        req1Valid = 1; req1Write = 0; req1Address = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_checks++; if (s_done !== 0 || s_r0 !== 0 || s_r1 !== 0)
                $display("FAIL init_idle cyc %0d got done=%b rdy=%b%b want 0 00", i, s_done, s_r1, s_r0); else n_pass++;
            n_checks++; if (s_we !== 1 || s_wa !== AW'(i) || s_wd !== 0 || s_wbe !== 4'hF)
                $display("FAIL init_write cyc %0d got we=%b a=%0d d=%h be=%b want 1 %0d 0 f", i, s_we, s_wa, s_wd, s_wbe, i); else n_pass++;
        end
        model_reset();
        model_cycle();
        tick();
        n_checks++; if (s_done !== 1) $display("FAIL init_done_cyc16 got %b want 1", s_done); else n_pass++;
        n_checks++; if (s_r0 !== e_g0 || s_r1 !== e_g1 || s_r0 !== 1)
            $display("FAIL init_first_grant got %b%b want %b%b", s_r1, s_r0, e_g1, e_g0); else n_pass++;
        req1Valid = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i < DEPTH) begin req0Address = AW'(i); end else begin idle_inputs(); end
            model_cycle();
            tick();
            n_checks++; if (s_rv0 !== 1 || s_rd0 !== 0 || s_rd0 !== e_rdata)
                $display("FAIL init_readback addr %0d got v=%b d=%h want 1 00000000", i - 1, s_rv0, s_rd0); else n_pass++;
        end
    endtask

    task automatic test_single;
        req0Valid = 1; req0Write = 1; req0Address = 2; req0Data = 32'hAAAA8888; req0ByteEnable = 4'hF;
        model_cycle(); tick();
        n_checks++; if (s_r0 !== 1) $display("FAIL single_wr_ready got %b want 1", s_r0); else n_pass++;
        req0Write = 0;
        model_cycle(); tick();
        n_checks++; if (s_r0 !== 1 || s_rv0 !== 0) $display("FAIL single_rd_ready got r=%b v=%b want 1 0", s_r0, s_rv0); else n_pass++;
        idle_inputs();
        model_cycle(); tick();
        n_checks++; if (s_rv0 !== 1 || s_rd0 !== 32'hAAAA8888 || s_rd0 !== e_rdata)
            $display("FAIL single_resp got v=%b d=%h want 1 aaaa8888", s_rv0, s_rd0); else n_pass++;
        n_checks++; if (s_rv1 !== 0) $display("FAIL single_resp1_quiet got %b want 0", s_rv1); else n_pass++;
    endtask

    task automatic test_contention;
        logic [DW-1:0] want;
        req1Valid = 1; req1Write = 1; req1Address = 4; req1Data = 32'h11110000; req1ByteEnable = 4'hF;
        model_cycle(); tick();
        n_checks++; if (s_r1 !== 1) $display("FAIL cont_prep_ready got %b want 1", s_r1); else n_pass++;
        req0Valid = 1; req0Write = 0; req0Address = 2;
        req1Valid = 1; req1Write = 0; req1Address = 4;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle_inputs();
            model_cycle(); tick();
            if (k < 4) begin
                n_checks++; if (s_r0 !== (k % 2 == 0) || s_r1 !== (k % 2 == 1) || s_r0 !== e_g0)
                    $display("FAIL cont_grant cyc %0d got %b%b want port %0d", k, s_r1, s_r0, k % 2); else n_pass++;
            end
            if (k > 0) begin
                want = ((k - 1) % 2 == 0) ? 32'hAAAA8888 : 32'h11110000;
                n_checks++; if (s_rv0 !== ((k - 1) % 2 == 0) || s_rv1 !== ((k - 1) % 2 == 1) || s_rd0 !== want)
                    $display("FAIL cont_resp cyc %0d got v=%b%b d=%h want %h", k, s_rv1, s_rv0, s_rd0, want); else n_pass++;
            end
        end
    endtask

    task automatic test_mixed;
        req0Valid = 1; req0Write = 1; req0Address = 4; req0Data = 32'h5A5A1234; req0ByteEnable = 4'hF;
        req1Valid = 1; req1Write = 0; req1Address = 4;
        model_cycle(); tick();
        n_checks++; if (s_r0 !== 1 || s_r1 !== 0) $display("FAIL mixed_first got %b%b want 01", s_r1, s_r0); else n_pass++;
        req0Valid = 0;
        model_cycle(); tick();
        n_checks++; if (s_r1 !== 1) $display("FAIL mixed_second got %b want 1", s_r1); else n_pass++;
        idle_inputs();
        model_cycle(); tick();
        n_checks++; if (s_rv1 !== 1 || s_rd1 !== 32'h5A5A1234 || s_rd1 !== e_rdata)
            $display("FAIL mixed_resp got v=%b d=%h want 1 5a5a1234", s_rv1, s_rd1); else n_pass++;
    endtask

    task automatic test_byte_en;
        req0Valid = 1; req0Write = 1; req0Address = 2; req0Data = 32'h00000064; req0ByteEnable = 4'b0011;
        model_cycle(); tick();
        req0Write = 0;
        model_cycle(); tick();
        idle_inputs();
        model_cycle(); tick();
        n_checks++; if (s_rv0 !== 1 || s_rd0 !== 32'hAAAA0064 || s_rd0 !== e_rdata)
            $display("FAIL byte_en_resp got v=%b d=%h want 1 aaaa0064", s_rv0, s_rd0); else n_pass++;
    endtask

    task automatic test_random;
        for (int c = 0; c < 200; c++) begin
            req0Valid = 1'($urandom_range(0, 1)); req0Write = 1'($urandom_range(0, 1));
            req0Address = AW'($urandom_range(0, DEPTH - 1)); req0Data = $urandom; req0ByteEnable = 4'($urandom);
            req1Valid = 1'($urandom_range(0, 1)); req1Write = 1'($urandom_range(0, 1));
            req1Address = AW'($urandom_range(0, DEPTH - 1)); req1Data = $urandom; req1ByteEnable = 4'($urandom);
            if (c == 199) idle_inputs();
            model_cycle(); tick();
            n_checks++; if (s_r0 !== e_g0 || s_r1 !== e_g1)
                $display("FAIL rand_grant cyc %0d got %b%b want %b%b", c, s_r1, s_r0, e_g1, e_g0); else n_pass++;
            n_checks++; if (s_rv0 !== e_rv0 || s_rv1 !== e_rv1)
                $display("FAIL rand_resp_valid cyc %0d got %b%b want %b%b", c, s_rv1, s_rv0, e_rv1, e_rv0); else n_pass++;
            if (e_rv0 || e_rv1) begin
                n_checks++; if ((e_rv0 ? s_rd0 : s_rd1) !== e_rdata)
                    $display("FAIL rand_resp_data cyc %0d got %h want %h", c, e_rv0 ? s_rd0 : s_rd1, e_rdata); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen_resp;
        req0Valid = 1; req0Write = 0; req0Address = 2; req1Valid = 0;
        model_cycle(); tick();
        n_checks++; if (s_r0 !== 1) $display("FAIL midrst_grant got %b want 1", s_r0); else n_pass++;
        reset = 1; idle_inputs();
        @(negedge clock);
        n_checks++; if (resp0Valid !== 0 || resp1Valid !== 0)
            $display("FAIL midrst_resp_dropped got %b%b want 00", resp1Valid, resp0Valid); else n_pass++;
        @(posedge clock); #1;
        reset = 0;
        seen_resp = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (s_rv0 || s_rv1) seen_resp = 1;
            n_checks++; if (s_we !== 1 || s_wa !== AW'(i) || s_done !== 0)
                $display("FAIL midrst_refill cyc %0d got we=%b a=%0d done=%b want 1 %0d 0", i, s_we, s_wa, s_done, i); else n_pass++;
        end
        n_checks++; if (seen_resp !== 0) $display("FAIL midrst_no_resp got %b want 0", seen_resp); else n_pass++;
        model_reset();
        req0Valid = 1; req0Write = 0; req0Address = 2;
        model_cycle(); tick();
        n_checks++; if (s_done !== 1 || s_r0 !== 1) $display("FAIL midrst_run got done=%b r=%b want 1 1", s_done, s_r0); else n_pass++;
        idle_inputs();
        model_cycle(); tick();
        n_checks++; if (s_rv0 !== 1 || s_rd0 !== 0 || s_rd0 !== e_rdata)
            $display("FAIL midrst_cleared got v=%b d=%h want 1 00000000", s_rv0, s_rd0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_contention();
        test_mixed();
        test_byte_en();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
